// File: rtl/csr_regfile.sv
// Machine-mode Zicsr register file: CSR read/modify/write, 64-bit cycle/instret
// counters, trap entry/mret bookkeeping and interrupt-pending status.
module csr_regfile #(
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_csr_en,
   input  logic [1:0]  i_csr_op,
   input  logic [11:0] i_csr_addr,
   input  logic [31:0] i_csr_wdata,
   input  logic        i_wr_suppress,
   output logic [31:0] o_csr_rdata,
   output logic        o_illegal,
   input  logic        i_instret,
   input  logic        i_trap,
   input  logic [31:0] i_trap_cause,
   input  logic [31:0] i_trap_pc,
   input  logic [31:0] i_trap_val,
   input  logic        i_mret,
   input  logic        i_ext_irq,
   input  logic        i_timer_irq,
   input  logic        i_sw_irq,
   output logic [31:0] o_trap_vector,
   output logic [31:0] o_epc,
   output logic        o_irq_pending
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;
   localparam logic [11:0] A_MIMPID    = 12'hF13;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [1:0]  OP_RW = 2'b01;
   localparam logic [1:0]  OP_RS = 2'b10;
   localparam logic [1:0]  OP_RC = 2'b11;

   localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic [31:0] mie_r;
   logic [31:0] mtvec_r;
   logic [31:0] mscratch_r;
   logic [31:0] mepc_r;
   logic [31:0] mcause_r;
   logic [31:0] mtval_r;
   logic [63:0] mcycle_r;
   logic [63:0] minstret_r;

   logic [31:0] mstatus_val;
   logic [31:0] mip_val;
   logic [31:0] old_val;
   logic [31:0] new_val;
   logic        addr_hit;
   logic        write_req;
   logic        wr_en;
   logic [63:0] cycle_inc;
   logic [63:0] instret_inc;
   logic [31:0] vec_offset;

   assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
   assign mip_val     = {20'd0, i_ext_irq, 3'd0, i_timer_irq, 3'd0, i_sw_irq, 3'd0};

   // Read side: pure decode of the current (pre-write) CSR contents.
   always_comb begin
      old_val  = 32'd0;
      addr_hit = 1'b1;
      case (i_csr_addr)
         A_MSTATUS:                old_val = mstatus_val;
         A_MISA:                   old_val = MISA_VAL;
         A_MIE:                    old_val = mie_r;
         A_MTVEC:                  old_val = mtvec_r;
         A_MSCRATCH:               old_val = mscratch_r;
         A_MEPC:                   old_val = mepc_r;
         A_MCAUSE:                 old_val = mcause_r;
         A_MTVAL:                  old_val = mtval_r;
         A_MIP:                    old_val = mip_val;
         A_MCYCLE,   A_CYCLE:      old_val = mcycle_r[31:0];
         A_MCYCLEH,  A_CYCLEH:     old_val = mcycle_r[63:32];
         A_MINSTRET, A_INSTRET:    old_val = minstret_r[31:0];
         A_MINSTRETH, A_INSTRETH:  old_val = minstret_r[63:32];
         A_MVENDORID, A_MARCHID, A_MIMPID: old_val = 32'd0;
         A_MHARTID:                old_val = HART_ID;
         default:                  addr_hit = 1'b0;
      endcase
   end

   // i_csr_en is a one-cycle valid with no back-pressure: the access is
   // answered combinationally and any write commits at the next rising edge.
   assign write_req = i_csr_en & (i_csr_op != 2'b00) & ~i_wr_suppress;
   assign o_illegal = i_csr_en & (i_csr_op != 2'b00) &
                      (~addr_hit | (write_req & (i_csr_addr[11:10] == 2'b11)));
   assign wr_en     = write_req & ~o_illegal;
   assign o_csr_rdata = old_val;

   always_comb begin
      new_val = old_val;
      case (i_csr_op)
         OP_RW:   new_val = i_csr_wdata;
         OP_RS:   new_val = old_val | i_csr_wdata;
         OP_RC:   new_val = old_val & ~i_csr_wdata;
         default: new_val = old_val;
      endcase
   end

   assign cycle_inc   = mcycle_r + 64'd1;
   assign instret_inc = minstret_r + {63'd0, i_instret};

   assign vec_offset    = (mtvec_r[1:0] == 2'b01 && i_trap_cause[31])
                          ? {25'd0, i_trap_cause[4:0], 2'b00} : 32'd0;
   assign o_trap_vector = {mtvec_r[31:2], 2'b00} + vec_offset;
   assign o_epc         = mepc_r;
   assign o_irq_pending = mstatus_mie & |(mie_r & mip_val);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_r        <= 32'd0;
         mtvec_r      <= MTVEC_RESET;
         mscratch_r   <= 32'd0;
         mepc_r       <= 32'd0;
         mcause_r     <= 32'd0;
         mtval_r      <= 32'd0;
         mcycle_r     <= 64'd0;
         minstret_r   <= 64'd0;
      end else begin
         // Trap beats mret beats a software write for the fields they share.
         if (i_trap) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (i_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (wr_en && i_csr_addr == A_MSTATUS) begin
            mstatus_mie  <= new_val[3];
            mstatus_mpie <= new_val[7];
         end

         if (i_trap) begin
            mepc_r   <= {i_trap_pc[31:2], 2'b00};
            mcause_r <= i_trap_cause;
            mtval_r  <= i_trap_val;
         end else if (wr_en) begin
            if (i_csr_addr == A_MEPC)   mepc_r   <= {new_val[31:2], 2'b00};
            if (i_csr_addr == A_MCAUSE) mcause_r <= new_val;
            if (i_csr_addr == A_MTVAL)  mtval_r  <= new_val;
         end

         if (wr_en && i_csr_addr == A_MIE)      mie_r      <= new_val & IRQ_MASK;
         if (wr_en && i_csr_addr == A_MSCRATCH) mscratch_r <= new_val;

         // Reserved modes 1x leave the stored mode untouched; the base always updates.
         if (wr_en && i_csr_addr == A_MTVEC) begin
            mtvec_r[31:2] <= new_val[31:2];
            if (!new_val[1]) mtvec_r[1:0] <= new_val[1:0];
         end

         mcycle_r[31:0]    <= (wr_en && i_csr_addr == A_MCYCLE)    ? new_val : cycle_inc[31:0];
         mcycle_r[63:32]   <= (wr_en && i_csr_addr == A_MCYCLEH)   ? new_val : cycle_inc[63:32];
         minstret_r[31:0]  <= (wr_en && i_csr_addr == A_MINSTRET)  ? new_val : instret_inc[31:0];
         minstret_r[63:32] <= (wr_en && i_csr_addr == A_MINSTRETH) ? new_val : instret_inc[63:32];
      end
   end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed-vector bench for csr_regfile with hand-computed expectations.
module tb_csr_regfile;

   localparam logic [31:0] HART   = 32'd5;
   localparam logic [31:0] MTVEC0 = 32'h0000_0080;
   localparam logic [31:0] MISA   = 32'h4000_0100;

   logic        clk;
   logic        rst_n;
   logic        csr_en;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        wr_suppress;
   logic [31:0] csr_rdata;
   logic        illegal;
   logic        instret;
   logic        trap;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_val;
   logic        mret;
   logic        ext_irq;
   logic        timer_irq;
   logic        sw_irq;
   logic [31:0] trap_vector;
   logic [31:0] epc;
   logic        irq_pending;

   int          n_checks;
   int          n_errors;
   logic [31:0] rd;
   logic        ill;
   logic [31:0] vec_seen;

   csr_regfile #(
      .HART_ID     (HART),
      .MTVEC_RESET (MTVEC0),
      .MISA_VAL    (MISA)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_csr_en      (csr_en),
      .i_csr_op      (csr_op),
      .i_csr_addr    (csr_addr),
      .i_csr_wdata   (csr_wdata),
      .i_wr_suppress (wr_suppress),
      .o_csr_rdata   (csr_rdata),
      .o_illegal     (illegal),
      .i_instret     (instret),
      .i_trap        (trap),
      .i_trap_cause  (trap_cause),
      .i_trap_pc     (trap_pc),
      .i_trap_val    (trap_val),
      .i_mret        (mret),
      .i_ext_irq     (ext_irq),
      .i_timer_irq   (timer_irq),
      .i_sw_irq      (sw_irq),
      .o_trap_vector (trap_vector),
      .o_epc         (epc),
      .o_irq_pending (irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One clock of CSR traffic; side-band trap/mret/instret set beforehand apply to the same edge.
   task automatic do_cycle(input logic en, input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic sup);
      @(negedge clk);
      csr_en      = en;
      csr_op      = op;
      csr_addr    = addr;
      csr_wdata   = wdata;
      wr_suppress = sup;
      #1;
      rd       = csr_rdata;
      ill      = illegal;
      vec_seen = trap_vector;
      @(posedge clk);
      #1;
      csr_en  = 1'b0;
      csr_op  = 2'b00;
      trap    = 1'b0;
      mret    = 1'b0;
      instret = 1'b0;
   endtask

   task automatic rd_csr(input logic [11:0] addr);
      do_cycle(1'b1, 2'b10, addr, 32'd0, 1'b1);
   endtask

   task automatic wr_csr(input logic [11:0] addr, input logic [31:0] wdata);
      do_cycle(1'b1, 2'b01, addr, wdata, 1'b0);
   endtask

   logic [11:0] rst_addr [0:18];
   logic [31:0] rst_exp  [0:18];

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'd0;
      wr_suppress = 1'b0; instret = 1'b0; trap = 1'b0; trap_cause = 32'd0; trap_pc = 32'd0;
      trap_val = 32'd0; mret = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0; sw_irq = 1'b0;

      rst_addr = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                   12'h344, 12'hB80, 12'hB02, 12'hB82, 12'hC02, 12'hC80, 12'hC82,
                   12'hF11, 12'hF12, 12'hF13, 12'hF14};
      rst_exp  = '{32'h0000_1800, MISA, 32'd0, MTVEC0, 32'd0, 32'd0, 32'd0, 32'd0,
                   32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                   32'd0, 32'd0, 32'd0, HART};

      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
      check_eq("rst_epc", epc, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         rd_csr(rst_addr[i]);
         check_eq($sformatf("rst_read_%03h", rst_addr[i]), rd, rst_exp[i]);
         check_eq($sformatf("rst_legal_%03h", rst_addr[i]), {31'd0, ill}, 32'd0);
      end
      rd_csr(12'hB00);
      check_eq("rst_mcycle_small", {31'd0, (rd >= 32'd1 && rd <= 32'd40)}, 32'd1);

      // mscratch read-modify-write sequence returns old values.
      wr_csr(12'h340, 32'hDEAD_BEEF);
      check_eq("rw_old", rd, 32'd0);
      do_cycle(1'b1, 2'b10, 12'h340, 32'h0000_0010, 1'b0);
      check_eq("rs_old", rd, 32'hDEAD_BEEF);
      do_cycle(1'b1, 2'b11, 12'h340, 32'hDE00_0000, 1'b0);
      check_eq("rc_old", rd, 32'hDEAD_BEFF);
      rd_csr(12'h340);
      check_eq("mscratch_final", rd, 32'h00AD_BEFF);

      // Low-half carry into mcycleh, then full 64-bit wrap.
      wr_csr(12'hB00, 32'hFFFF_FFFF);
      rd_csr(12'hB00);
      check_eq("mcycle_written", rd, 32'hFFFF_FFFF);
      rd_csr(12'hB00);
      check_eq("mcycle_rolled", rd, 32'd0);
      rd_csr(12'hB80);
      check_eq("mcycleh_carry", rd, 32'd1);
      wr_csr(12'hB80, 32'hFFFF_FFFF);
      wr_csr(12'hB00, 32'hFFFF_FFFF);
      rd_csr(12'hB80);
      check_eq("mcycleh_pre_wrap", rd, 32'hFFFF_FFFF);
      rd_csr(12'hB80);
      check_eq("mcycleh_wrap", rd, 32'd0);
      rd_csr(12'hC00);
      check_eq("cycle_wrap_low", rd, 32'd1);
      check_eq("cycle_read_legal", {31'd0, ill}, 32'd0);

      // minstret: software write wins over the retire increment.
      instret = 1'b1;
      wr_csr(12'hB02, 32'h0000_0100);
      rd_csr(12'hB02);
      check_eq("minstret_write_wins", rd, 32'h0000_0100);
      instret = 1'b1;
      rd_csr(12'hB02);
      rd_csr(12'hC02);
      check_eq("minstret_inc", rd, 32'h0000_0101);

      // mepc low bits forced to zero; mtvec reserved modes; misa ignores writes.
      wr_csr(12'h341, 32'h0000_1003);
      check_eq("epc_out", epc, 32'h0000_1000);
      wr_csr(12'h305, 32'h0000_0101);
      wr_csr(12'h305, 32'h0000_0203);
      rd_csr(12'h305);
      check_eq("mtvec_mode_kept", rd, 32'h0000_0201);
      wr_csr(12'h305, 32'h0000_0101);
      wr_csr(12'h301, 32'h0000_0000);
      check_eq("misa_write_legal", {31'd0, ill}, 32'd0);
      rd_csr(12'h301);
      check_eq("misa_unchanged", rd, MISA);

      // Interrupt pending, vectored trap entry and mret.
      wr_csr(12'h300, 32'h0000_0008);
      wr_csr(12'h304, 32'hFFFF_FFFF);
      rd_csr(12'h304);
      check_eq("mie_mask", rd, 32'h0000_0888);
      wr_csr(12'h304, 32'h0000_0800);
      check_eq("irq_off_no_line", {31'd0, irq_pending}, 32'd0);
      ext_irq = 1'b1;
      rd_csr(12'h344);
      check_eq("mip_mirror", rd, 32'h0000_0800);
      check_eq("irq_pending", {31'd0, irq_pending}, 32'd1);
      trap = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_2003; trap_val = 32'h0000_0077;
      do_cycle(1'b0, 2'b00, 12'h000, 32'd0, 1'b0);
      check_eq("trap_vector", vec_seen, 32'h0000_012C);
      check_eq("trap_epc", epc, 32'h0000_2000);
      check_eq("trap_irq_masked", {31'd0, irq_pending}, 32'd0);
      rd_csr(12'h300);
      check_eq("trap_mstatus", rd, 32'h0000_1880);
      rd_csr(12'h342);
      check_eq("trap_mcause", rd, 32'h8000_000B);
      rd_csr(12'h343);
      check_eq("trap_mtval", rd, 32'h0000_0077);
      trap_cause = 32'h0000_0002;
      #1;
      check_eq("sync_vector_base", trap_vector, 32'h0000_0100);
      mret = 1'b1;
      do_cycle(1'b0, 2'b00, 12'h000, 32'd0, 1'b0);
      rd_csr(12'h300);
      check_eq("mret_mstatus", rd, 32'h0000_1888);
      check_eq("mret_irq_pending", {31'd0, irq_pending}, 32'd1);

      // Illegal accesses change nothing.
      wr_csr(12'hF14, 32'h0000_0055);
      check_eq("mhartid_write_illegal", {31'd0, ill}, 32'd1);
      rd_csr(12'hF14);
      check_eq("mhartid_unchanged", rd, HART);
      wr_csr(12'h7C0, 32'h0000_1234);
      check_eq("unknown_addr_illegal", {31'd0, ill}, 32'd1);
      do_cycle(1'b1, 2'b10, 12'hC00, 32'h0000_0001, 1'b0);
      check_eq("cycle_rs_write_illegal", {31'd0, ill}, 32'd1);
      rd_csr(12'h340);
      check_eq("mscratch_after_illegal", rd, 32'h00AD_BEFF);

      // Trap beats a same-cycle mepc write; mscratch still commits alongside a trap.
      trap = 1'b1; trap_cause = 32'h0000_0003; trap_pc = 32'h0000_3000; trap_val = 32'd0;
      wr_csr(12'h341, 32'h0000_4444);
      check_eq("trap_beats_mepc_write", epc, 32'h0000_3000);
      trap = 1'b1;
      wr_csr(12'h340, 32'h0000_1234);
      rd_csr(12'h340);
      check_eq("mscratch_with_trap", rd, 32'h0000_1234);

      // Reset in the middle of a write aborts it.
      @(negedge clk);
      csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h9999_9999;
      wr_suppress = 1'b0; rst_n = 1'b0;
      @(posedge clk);
      #1;
      csr_en = 1'b0; csr_op = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      rd_csr(12'h340);
      check_eq("midreset_mscratch", rd, 32'd0);
      rd_csr(12'h305);
      check_eq("midreset_mtvec", rd, MTVEC0);
      rd_csr(12'h300);
      check_eq("midreset_mstatus", rd, 32'h0000_1800);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
